// File: rtl/ifft64_radix2.sv
// ifft64_radix2: 64-point radix-2 decimation-in-time inverse FFT.
//   Serial complex input in natural bin order, serial complex output in natural time order.
//   One butterfly every two clocks (read, then in-place write-back); each stage halves the
//   data, so the six stages together apply the 1/64 normalisation.
// Ports:
//   clk_i            clock, rising edge
//   rst_ni           asynchronous reset, active low
//   in_en_i          input valid; a rising edge seen while idle starts a frame, low stalls
//   in_r_i, in_i_i   input sample, DW-bit two's complement
//   out_r_o, out_i_o output sample, saturated to DW bits
//   out_en_o         high while out_r_o/out_i_o carry a valid sample (64 cycles)
//   busy_o           high while a frame is being read, computed or written
// Build option:
//   IFFT64_FWD_EN    negate the twiddle imaginary part, giving a forward DFT scaled by 1/64.
module ifft64_radix2 #(
    parameter int unsigned NUMP = 64,
    parameter int unsigned DW   = 8,
    parameter int unsigned TW   = 8,
    parameter int unsigned IW   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_en_i,
    input  logic signed [DW-1:0] in_r_i,
    input  logic signed [DW-1:0] in_i_i,
    output logic signed [DW-1:0] out_r_o,
    output logic signed [DW-1:0] out_i_o,
    output logic                 out_en_o,
    output logic                 busy_o
);
    localparam int unsigned AW = $clog2(NUMP);
    localparam int unsigned PW = IW + TW;
    localparam int unsigned SW = IW + 1;
    localparam logic [8:0] CalLast = 9'd383;

    typedef enum logic [1:0] {StIdle, StRead, StCal, StWrite} state_e;

    state_e               state_q, state_d;
    logic [8:0]           cnt_q, cnt_d;
    logic                 in_en_q;
    logic signed [DW-1:0] out_r_q, out_r_d, out_i_q, out_i_d;
    logic                 out_en_q, out_en_d;
    logic signed [IW-1:0] a_r_q, a_i_q, b_r_q, b_i_q;
    logic signed [IW-1:0] mem_r_q [NUMP];
    logic signed [IW-1:0] mem_i_q [NUMP];

    logic                 wr_in, wr_bf, ab_ld;
    logic [AW-1:0]        wa_in;
    logic signed [IW-1:0] ext_r, ext_i;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) r[i] = v[AW-1-i];
        return r;
    endfunction

    function automatic logic signed [DW-1:0] sat(input logic signed [IW-1:0] v);
        // In range when every bit above the DW sign bit matches it.
        if ((&v[IW-1:DW-1]) || !(|v[IW-1:DW-1])) return v[DW-1:0];
        else if (v[IW-1]) return {1'b1, {(DW-1){1'b0}}};
        else return {1'b0, {(DW-1){1'b1}}};
    endfunction

    // round(127*cos(i*2*pi/64)) for i = 0..16; the rest of the circle is folded onto this.
    function automatic logic signed [TW-1:0] quarter(input logic [4:0] i);
        case (i)
            5'd0:    return 8'sd127;
            5'd1:    return 8'sd126;
            5'd2:    return 8'sd125;
            5'd3:    return 8'sd122;
            5'd4:    return 8'sd117;
            5'd5:    return 8'sd112;
            5'd6:    return 8'sd106;
            5'd7:    return 8'sd98;
            5'd8:    return 8'sd90;
            5'd9:    return 8'sd81;
            5'd10:   return 8'sd71;
            5'd11:   return 8'sd60;
            5'd12:   return 8'sd49;
            5'd13:   return 8'sd37;
            5'd14:   return 8'sd25;
            5'd15:   return 8'sd12;
            default: return 8'sd0;
        endcase
    endfunction

    // Butterfly addressing: cnt_q = {stage[2:0], butterfly[4:0], phase}.
    logic [2:0]           stage;
    logic [4:0]           bf, j, k;
    logic [AW-1:0]        p_lo, p_hi;
    logic signed [TW-1:0] w_r, w_i, sin_k;

    always_comb begin
        stage = cnt_q[8:6];
        bf    = cnt_q[5:1];
        j     = bf & ((5'd1 << stage) - 5'd1);
        p_lo  = ({1'b0, bf >> stage} << (stage + 3'd1)) | {1'b0, j};
        p_hi  = p_lo | (6'd1 << stage);
        k     = j << (3'd5 - stage);
        w_r   = (k <= 5'd16) ? quarter(k) : -quarter(5'd0 - k);
        sin_k = (k <= 5'd16) ? quarter(5'd16 - k) : quarter(k - 5'd16);
`ifdef IFFT64_FWD_EN
        w_i   = -sin_k;
`else
        w_i   = sin_k;
`endif
    end

    // t = b * W (Q1.7), then a' = (a + t) / 2, b' = (a - t) / 2.
    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [IW-1:0] t_r, t_i, ar_n, ai_n, br_n, bi_n;
    logic signed [SW-1:0] s_ar, s_ai, s_br, s_bi;

    assign p_rr = PW'(b_r_q) * PW'(w_r);
    assign p_ii = PW'(b_i_q) * PW'(w_i);
    assign p_ri = PW'(b_r_q) * PW'(w_i);
    assign p_ir = PW'(b_i_q) * PW'(w_r);
    assign t_r  = IW'((p_rr - p_ii) >>> (TW - 1));
    assign t_i  = IW'((p_ri + p_ir) >>> (TW - 1));
    assign s_ar = SW'(a_r_q) + SW'(t_r);
    assign s_ai = SW'(a_i_q) + SW'(t_i);
    assign s_br = SW'(a_r_q) - SW'(t_r);
    assign s_bi = SW'(a_i_q) - SW'(t_i);
    assign ar_n = IW'(s_ar >>> 1);
    assign ai_n = IW'(s_ai >>> 1);
    assign br_n = IW'(s_br >>> 1);
    assign bi_n = IW'(s_bi >>> 1);

    assign wa_in = bitrev(cnt_q[AW-1:0]);
    assign ext_r = {{(IW-DW){in_r_i[DW-1]}}, in_r_i};
    assign ext_i = {{(IW-DW){in_i_i[DW-1]}}, in_i_i};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        out_r_d  = out_r_q;
        out_i_d  = out_i_q;
        out_en_d = 1'b0;
        wr_in    = 1'b0;
        wr_bf    = 1'b0;
        ab_ld    = 1'b0;
        case (state_q)
            StIdle: begin
                if (in_en_i && !in_en_q) begin
                    wr_in   = 1'b1;
                    cnt_d   = 9'd1;
                    state_d = StRead;
                end
            end
            StRead: begin
                if (in_en_i) begin
                    wr_in = 1'b1;
                    cnt_d = cnt_q + 9'd1;
                    if (cnt_q[AW-1:0] == 6'd63) begin
                        cnt_d   = '0;
                        state_d = StCal;
                    end
                end
            end
            StCal: begin
                cnt_d = cnt_q + 9'd1;
                if (!cnt_q[0]) ab_ld = 1'b1;
                else           wr_bf = 1'b1;
                if (cnt_q == CalLast) begin
                    cnt_d   = '0;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (!cnt_q[AW]) begin
                    out_r_d  = sat(mem_r_q[cnt_q[AW-1:0]]);
                    out_i_d  = sat(mem_i_q[cnt_q[AW-1:0]]);
                    out_en_d = 1'b1;
                    cnt_d    = cnt_q + 9'd1;
                end else begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            in_en_q  <= 1'b0;
            out_r_q  <= '0;
            out_i_q  <= '0;
            out_en_q <= 1'b0;
            a_r_q    <= '0;
            a_i_q    <= '0;
            b_r_q    <= '0;
            b_i_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            in_en_q  <= in_en_i;
            out_r_q  <= out_r_d;
            out_i_q  <= out_i_d;
            out_en_q <= out_en_d;
            if (ab_ld) begin
                a_r_q <= mem_r_q[p_lo];
                a_i_q <= mem_i_q[p_lo];
                b_r_q <= mem_r_q[p_hi];
                b_i_q <= mem_i_q[p_hi];
            end
        end
    end

    // Working memory needs no reset: every frame overwrites all 64 entries before use.
    always_ff @(posedge clk_i) begin
        if (wr_in) begin
            mem_r_q[wa_in] <= ext_r;
            mem_i_q[wa_in] <= ext_i;
        end
        if (wr_bf) begin
            mem_r_q[p_lo] <= ar_n;
            mem_i_q[p_lo] <= ai_n;
            mem_r_q[p_hi] <= br_n;
            mem_i_q[p_hi] <= bi_n;
        end
    end

    assign out_r_o  = out_r_q;
    assign out_i_o  = out_i_q;
    assign out_en_o = out_en_q;
    assign busy_o   = (state_q != StIdle);

endmodule
